// File: rtl/axi_vga_fetch_ctrl.sv
// Frame-buffer fetch controller: walks one frame per frame_start and issues AXI
// INCR read bursts clipped to burst length, remaining frame and 4 KiB pages.
//
// state | meaning
// IDLE  | waiting for frame_start with fetch enabled
// ISSUE | computing, credit-gating and presenting AR bursts
// DRAIN | all bursts issued or fetch aborted; waiting for outstanding R beats
module axi_vga_fetch_ctrl #(
  parameter int AddrWidth = 48,
  parameter int DataWidth = 64,
  parameter int FifoDepth = 512,
  localparam int Bpb = DataWidth / 8,
  localparam int BpbLog = $clog2(Bpb),
  localparam int CW = $clog2(FifoDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 frame_start_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [31:0]          frame_size_i,
  input  logic [7:0]           burst_len_i,
  input  logic [CW-1:0]        fifo_free_i,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [7:0]           ar_len_o,
  input  logic                 r_beat_i,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 overrun_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state;
  logic [AddrWidth-1:0] addr;
  logic [31:0]          beats_left;
  logic [CW-1:0]        inflight;
  logic [7:0]           max_len;
  logic [8:0]           burst_n;

  logic [12:0]          page_room;
  logic [8:0]           len_cap;
  logic [8:0]           left_cap;
  logic [8:0]           room_cap;
  logic [8:0]           n_beats;
  logic                 credit_ok;
  logic                 ar_hs;
  logic [CW-1:0]        inflight_nxt;
  logic [32:0]          size_round;
  logic [31:0]          frame_beats;
  logic [AddrWidth-1:0] base_aligned;

  // Beats left before the next 4 KiB page; addr is always beat-aligned so this is >= 1.
  assign page_room = (13'd4096 - {1'b0, addr[11:0]}) >> BpbLog;
  assign len_cap   = {1'b0, max_len} + 9'd1;
  assign left_cap  = (beats_left > 32'd256) ? 9'd256 : beats_left[8:0];
  assign room_cap  = (page_room > 13'd256) ? 9'd256 : page_room[8:0];

  always_comb begin
    n_beats = len_cap;
    if (left_cap < n_beats) n_beats = left_cap;
    if (room_cap < n_beats) n_beats = room_cap;
  end

  assign credit_ok    = 32'(fifo_free_i) >= (32'(inflight) + 32'(n_beats));
  assign ar_hs        = ar_valid_o & ar_ready_i;
  assign size_round   = {1'b0, frame_size_i} + 33'(Bpb - 1);
  assign frame_beats  = 32'(size_round >> BpbLog);
  assign base_aligned = start_addr_i & ~AddrWidth'(Bpb - 1);

  always_comb begin
    inflight_nxt = inflight;
    if (ar_hs)    inflight_nxt = inflight_nxt + CW'(burst_n);
    if (r_beat_i) inflight_nxt = inflight_nxt - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      addr         <= '0;
      beats_left   <= '0;
      inflight     <= '0;
      max_len      <= '0;
      burst_n      <= '0;
      ar_valid_o   <= 1'b0;
      ar_addr_o    <= '0;
      ar_len_o     <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
      inflight     <= inflight_nxt;
      case (state)
        IDLE: begin
          if (frame_start_i && enable_i) begin
            addr       <= base_aligned;
            beats_left <= frame_beats;
            max_len    <= burst_len_i;
            if (frame_beats == 32'd0) begin
              frame_done_o <= 1'b1;
            end else begin
              state  <= ISSUE;
              busy_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          overrun_o <= frame_start_i;
          if (ar_valid_o) begin
            // A presented burst is frozen until accepted, whatever enable or credits do.
            if (ar_ready_i) begin
              ar_valid_o <= 1'b0;
              addr       <= addr + (AddrWidth'(burst_n) << BpbLog);
              beats_left <= beats_left - 32'(burst_n);
              if (beats_left == 32'(burst_n)) state <= DRAIN;
            end
          end else if (!enable_i || beats_left == 32'd0) begin
            state <= DRAIN;
          end else if (credit_ok) begin
            ar_valid_o <= 1'b1;
            ar_addr_o  <= addr;
            ar_len_o   <= n_beats[7:0] - 8'd1;
            burst_n    <= n_beats;
          end
        end
        DRAIN: begin
          overrun_o <= frame_start_i;
          if (inflight_nxt == '0) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            frame_done_o <= (beats_left == 32'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credit underflow means the R channel returned data nobody asked for.
  r_beat_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_beat_i |-> (inflight != '0));

endmodule

// File: tb/tb_axi_vga_fetch_ctrl.sv
// Scoreboard bench for axi_vga_fetch_ctrl: directed frames push expected AR bursts,
// a negedge monitor pops and compares them on each AR handshake.
module tb_axi_vga_fetch_ctrl;
  localparam int AW = 48;
  localparam int CW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  logic          clk_i;
  logic          rst_ni;
  logic          enable_i;
  logic          frame_start_i;
  logic [AW-1:0] start_addr_i;
  logic [31:0]   frame_size_i;
  logic [7:0]    burst_len_i;
  logic [CW-1:0] fifo_free_i;
  logic          ar_valid_o;
  logic          ar_ready_i;
  logic [AW-1:0] ar_addr_o;
  logic [7:0]    ar_len_o;
  logic          r_beat_i;
  logic          busy_o;
  logic          frame_done_o;
  logic          overrun_o;

  int vectors = 0;
  int miscompares = 0;
  int ar_count = 0;
  int done_count = 0;
  int overrun_count = 0;
  int r_budget = 0;
  ar_t exp_q[$];

  axi_vga_fetch_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .frame_start_i (frame_start_i),
    .start_addr_i  (start_addr_i),
    .frame_size_i  (frame_size_i),
    .burst_len_i   (burst_len_i),
    .fifo_free_i   (fifo_free_i),
    .ar_valid_o    (ar_valid_o),
    .ar_ready_i    (ar_ready_i),
    .ar_addr_o     (ar_addr_o),
    .ar_len_o      (ar_len_o),
    .r_beat_i      (r_beat_i),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .overrun_o     (overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000 cycles");
    $fatal(1);
  end

  // AR monitor / scoreboard.
  initial begin : monitor
    ar_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && ar_valid_o && ar_ready_i) begin
        vectors++;
        ar_count++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL ar_unexpected: got addr=%h len=%0d, required no AR", ar_addr_o, ar_len_o);
        end else begin
          e = exp_q.pop_front();
          if (ar_addr_o !== e.addr || ar_len_o !== e.len) begin
            miscompares++;
            $display("FAIL ar_burst: got addr=%h len=%0d, required addr=%h len=%0d",
                     ar_addr_o, ar_len_o, e.addr, e.len);
          end
        end
      end
      if (rst_ni && frame_done_o) done_count++;
      if (rst_ni && overrun_o) overrun_count++;
    end
  end

  // R responder: returns one beat per cycle for accepted bursts, limited by r_budget.
  initial begin : responder
    int  pending;
    bit  hs;
    bit  beat;
    bit  rst_seen;
    int  hs_len;
    pending  = 0;
    r_beat_i = 1'b0;
    forever begin
      @(negedge clk_i);
      hs       = rst_ni && ar_valid_o && ar_ready_i;
      hs_len   = int'(ar_len_o);
      beat     = r_beat_i;
      rst_seen = rst_ni;
      @(posedge clk_i);
      #1;
      if (!rst_seen) begin
        pending = 0;
      end else begin
        if (beat) pending--;
        if (hs) pending += hs_len + 1;
      end
      if (pending > 0 && r_budget > 0) begin
        r_beat_i = 1'b1;
        r_budget--;
      end else begin
        r_beat_i = 1'b0;
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", tag, act, req);
    end
  endtask

  task automatic push_ar(input logic [AW-1:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  task automatic set_frame(input logic [AW-1:0] a, input logic [31:0] sz, input logic [7:0] bl);
    start_addr_i = a;
    frame_size_i = sz;
    burst_len_i  = bl;
  endtask

  task automatic pulse_start();
    frame_start_i = 1'b1;
    step(1);
    frame_start_i = 1'b0;
  endtask

  task automatic wait_frame_done(input int base_cnt, input string tag);
    int c;
    c = 0;
    while (done_count == base_cnt && c < 2000) begin
      step(1);
      c++;
    end
    vectors++;
    if (done_count == base_cnt) begin
      miscompares++;
      $display("FAIL %s: got no frame_done within 2000 cycles, required one", tag);
    end
  endtask

  task automatic wait_ar_valid(input string tag);
    int c;
    c = 0;
    while (!ar_valid_o && c < 200) begin
      step(1);
      c++;
    end
    check(tag, 64'(ar_valid_o), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy_o && c < 2000) begin
      step(1);
      c++;
    end
    check(tag, 64'(busy_o), 64'd0);
  endtask

  initial begin : stimulus
    int d0;
    int a0;
    int o0;
    rst_ni        = 1'b0;
    enable_i      = 1'b1;
    frame_start_i = 1'b0;
    ar_ready_i    = 1'b1;
    fifo_free_i   = 10'd512;
    set_frame(48'h0, 32'h0, 8'hFF);
    step(3);

    check("rst_ar_valid", 64'(ar_valid_o), 64'd0);
    check("rst_ar_addr", 64'(ar_addr_o), 64'd0);
    check("rst_ar_len", 64'(ar_len_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_frame_done", 64'(frame_done_o), 64'd0);
    check("rst_overrun", 64'(overrun_o), 64'd0);
    rst_ni = 1'b1;
    step(2);

    // Disabled: frame_start ignored, no overrun.
    enable_i = 1'b0;
    o0 = overrun_count;
    pulse_start();
    step(2);
    check("disabled_busy", 64'(busy_o), 64'd0);
    check("disabled_overrun", 64'(overrun_count), 64'(o0));
    enable_i = 1'b1;

    // 4 KiB boundary clipping.
    r_budget = 1000000;
    set_frame(48'h0000_8000_07F0, 32'h840, 8'hFF);
    push_ar(48'h0000_8000_07F0, 8'd255);
    push_ar(48'h0000_8000_0FF0, 8'd1);
    push_ar(48'h0000_8000_1000, 8'd5);
    d0 = done_count;
    pulse_start();
    check("first_ar_t1", 64'(ar_valid_o), 64'd0);
    check("first_busy_t1", 64'(busy_o), 64'd1);
    step(1);
    check("first_ar_t2", 64'(ar_valid_o), 64'd1);
    wait_frame_done(d0, "clip_done");
    step(5);
    check("clip_done_count", 64'(done_count), 64'(d0 + 1));
    check("clip_all_ars", 64'(exp_q.size()), 64'd0);
    check("clip_idle", 64'(busy_o), 64'd0);

    // Credit gating with R stalled.
    r_budget    = 0;
    fifo_free_i = 10'd100;
    set_frame(48'h0, 32'h1000, 8'h3F);
    push_ar(48'h0, 8'd63);
    a0 = ar_count;
    d0 = done_count;
    pulse_start();
    step(20);
    check("credit_one_ar", 64'(ar_count), 64'(a0 + 1));
    check("credit_blocked", 64'(ar_valid_o), 64'd0);
    r_budget = 27;
    step(40);
    check("credit_27_blocked", 64'(ar_valid_o), 64'd0);
    check("credit_27_count", 64'(ar_count), 64'(a0 + 1));
    push_ar(48'h200, 8'd63);
    r_budget = 1;
    step(8);
    check("credit_28_second_ar", 64'(ar_count), 64'(a0 + 2));
    for (int i = 2; i < 8; i++) push_ar(AW'(i * 32'h200), 8'd63);
    fifo_free_i = 10'd512;
    r_budget    = 1000000;
    wait_frame_done(d0, "credit_done");
    step(3);
    check("credit_all_ars", 64'(exp_q.size()), 64'd0);

    // AR backpressure: held burst must not move while enable/credits/config change.
    ar_ready_i = 1'b0;
    set_frame(48'h1000, 32'h400, 8'h0F);
    d0 = done_count;
    pulse_start();
    wait_ar_valid("bp_ar_valid_up");
    for (int i = 0; i < 10; i++) begin
      if (i == 2) enable_i = 1'b0;
      fifo_free_i  = CW'(3 + i * 7);
      start_addr_i = AW'(48'h9000 + i * 64);
      burst_len_i  = 8'(i);
      step(1);
      check("bp_hold_valid", 64'(ar_valid_o), 64'd1);
      check("bp_hold_addr", 64'(ar_addr_o), 64'h1000);
      check("bp_hold_len", 64'(ar_len_o), 64'd15);
    end
    push_ar(48'h1000, 8'd15);
    fifo_free_i = 10'd512;
    ar_ready_i  = 1'b1;
    step(1);
    wait_idle("bp_drain_idle");
    step(3);
    check("bp_no_done", 64'(done_count), 64'(d0));
    check("bp_all_ars", 64'(exp_q.size()), 64'd0);
    enable_i = 1'b1;

    // Zero-size frame: immediate done, no AR.
    set_frame(48'h2000, 32'h0, 8'h0F);
    a0 = ar_count;
    d0 = done_count;
    pulse_start();
    check("zero_done_t1", 64'(frame_done_o), 64'd1);
    check("zero_busy", 64'(busy_o), 64'd0);
    step(1);
    check("zero_done_pulse", 64'(frame_done_o), 64'd0);
    step(3);
    check("zero_no_ar", 64'(ar_count), 64'(a0));
    check("zero_done_count", 64'(done_count), 64'(d0 + 1));

    // 9 bytes rounds up to two beats.
    set_frame(48'h2000, 32'd9, 8'h0F);
    push_ar(48'h2000, 8'd1);
    d0 = done_count;
    pulse_start();
    wait_frame_done(d0, "odd_done");
    step(2);
    check("odd_all_ars", 64'(exp_q.size()), 64'd0);

    // Overrun during DRAIN.
    r_budget = 0;
    set_frame(48'h3000, 32'h80, 8'h0F);
    push_ar(48'h3000, 8'd15);
    a0 = ar_count;
    d0 = done_count;
    pulse_start();
    step(10);
    check("ovr_busy_drain", 64'(busy_o), 64'd1);
    o0 = overrun_count;
    pulse_start();
    check("ovr_pulse", 64'(overrun_o), 64'd1);
    step(1);
    check("ovr_pulse_end", 64'(overrun_o), 64'd0);
    r_budget = 1000000;
    wait_frame_done(d0, "ovr_done");
    step(10);
    check("ovr_idle", 64'(busy_o), 64'd0);
    check("ovr_no_new_fetch", 64'(ar_count), 64'(a0 + 1));
    check("ovr_count", 64'(overrun_count), 64'(o0 + 1));

    // Reset mid-burst with one burst still outstanding.
    r_budget = 0;
    set_frame(48'h4000, 32'h100, 8'h0F);
    push_ar(48'h4000, 8'd15);
    a0 = ar_count;
    pulse_start();
    step(2);
    ar_ready_i = 1'b0;
    wait_ar_valid("rst_second_ar_up");
    check("rst_first_taken", 64'(ar_count), 64'(a0 + 1));
    rst_ni = 1'b0;
    step(1);
    check("mid_rst_ar_valid", 64'(ar_valid_o), 64'd0);
    check("mid_rst_ar_addr", 64'(ar_addr_o), 64'd0);
    check("mid_rst_ar_len", 64'(ar_len_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_frame_done", 64'(frame_done_o), 64'd0);
    check("mid_rst_overrun", 64'(overrun_o), 64'd0);
    rst_ni = 1'b1;
    step(2);
    // Exactly 16 credits: only passes if inflight was cleared by reset.
    fifo_free_i = 10'd16;
    ar_ready_i  = 1'b1;
    r_budget    = 1000000;
    push_ar(48'h4000, 8'd15);
    push_ar(48'h4080, 8'd15);
    d0 = done_count;
    pulse_start();
    step(1);
    check("post_rst_ar_t2", 64'(ar_valid_o), 64'd1);
    wait_frame_done(d0, "post_rst_done");
    step(3);
    check("post_rst_all_ars", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_vga_fetch_ctrl.md
# axi_vga_fetch_ctrl

Frame-buffer fetch controller for the AXI VGA engine. Once per frame it walks the frame buffer from a configured start address and issues AXI4 INCR read bursts, clipped to the programmed burst length, the remaining frame size and 4 KiB boundaries. Bursts are gated by a credit check against free pixel-FIFO space, so read data can never overflow the FIFO. It sits between the register file / timing generator and the AXI AR channel; the R channel is only observed, for credit return.

## Interface

- `AddrWidth`, 48, AXI address width.
- `DataWidth`, 64, AXI data width; bytes per beat `Bpb = DataWidth/8` (power of two).
- `FifoDepth`, 512, pixel FIFO depth in beats; sets credit counter width `CW = $clog2(FifoDepth+1)`.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `enable_i`  in  1  fetch enable (cfg reg).
- `frame_start_i`  in  1  one-cycle pulse from the timing generator at start of vertical blanking.
- `start_addr_i`  in  AddrWidth  frame buffer base; low `log2(Bpb)` bits ignored.
- `frame_size_i`  in  32  frame size in bytes; rounded up to whole beats.
- `burst_len_i`  in  8  max burst, AXI len encoding (beats-1).
- `fifo_free_i`  in  CW  free FIFO entries in beats.
- `ar_valid_o`  out  1  AR valid.
- `ar_ready_i`  in  1  AR ready.
- `ar_addr_o`  out  AddrWidth  burst address, beat-aligned.
- `ar_len_o`  out  8  burst len (beats-1); burst INCR, size `log2(Bpb)` fixed outside.
- `r_beat_i`  in  1  R handshake (`r_valid & r_ready`) for this master.
- `busy_o`  out  1  high in ISSUE or DRAIN.
- `frame_done_o`  out  1  one-cycle pulse when the last beat of a frame has returned.
- `overrun_o`  out  1  one-cycle pulse when `frame_start_i` arrives while busy.

## Operation

- States: IDLE, ISSUE, DRAIN.
- IDLE: on `frame_start_i & enable_i`, latch `addr = start_addr_i` with the low bits cleared and `beats_left = ceil(frame_size_i/Bpb)`, then go to ISSUE. If `beats_left == 0`, pulse `frame_done_o` and stay in IDLE.
- Burst size: `n = min(burst_len_i+1, beats_left, (4096 - addr[11:0])/Bpb)`. Minimum is 1.
- ISSUE, no burst pending: assert `ar_valid_o` with `ar_addr_o = addr` and `ar_len_o = n-1` only if `fifo_free_i >= inflight + n`. Otherwise wait.
- Once asserted, `ar_valid_o`, `ar_addr_o` and `ar_len_o` hold stable until `ar_ready_i`. This follows AXI; neither `enable_i` nor the inputs may change them.
- On AR handshake:
  - `addr += n*Bpb`
  - `beats_left -= n`
  - `inflight += n`
- Credit return: `inflight -= 1` on each `r_beat_i`. Simultaneous AR handshake and R beat gives `inflight += n-1`.
- ISSUE → DRAIN when `beats_left` reaches 0, or when `enable_i` is low with no AR pending.
- DRAIN → IDLE when `inflight == 0`. `frame_done_o` pulses on this transition only if `beats_left == 0`, i.e. the frame was not aborted.
- `frame_start_i` in ISSUE or DRAIN: ignored for fetch purposes and `overrun_o` pulses.
- `frame_start_i` in the same cycle as DRAIN → IDLE: ignored, with an `overrun_o` pulse.
- `enable_i` low in IDLE: `frame_start_i` is ignored with no overrun.
- Config inputs are sampled only at frame start. Changes mid-frame take effect on the next frame.
- `inflight` is never expected to go negative. An `r_beat_i` with `inflight == 0` is an assertion failure in simulation.

## Timing

- All outputs are registered. Reset values: `ar_valid_o=0`, `ar_addr_o=0`, `ar_len_o=0`, `busy_o=0`, `frame_done_o=0`, `overrun_o=0`; state IDLE, `inflight=0`, `beats_left=0`.
- `frame_start_i` at cycle t gives state ISSUE at t+1. The earliest `ar_valid_o` is t+2: `n` and the credit check are computed in ISSUE and registered.
- After an AR handshake at cycle h, the next `ar_valid_o` is h+2 at the earliest. This allows at most one AR per 2 cycles, which is sufficient for bursts of 2 or more beats.
- `fifo_free_i` is sampled in the cycle the decision is made. Credits consumed by a just-accepted burst are already counted via `inflight`.
- Final R beat at cycle r gives `frame_done_o` high in cycle r+1 and `busy_o` low in r+1.
- Reset mid-operation returns to reset values in the next cycle, regardless of the AR handshake. The upstream interconnect is reset together.

## Test plan

- Boundary clipping: base 0x800007F0, size 0x840, burst_len 0xFF, fifo_free 512, R returns immediately.
  - Required ARs: (0x800007F0, len 255), (0x80000FF0, len 1), (0x80001000, len 5).
  - Then exactly one `frame_done_o`.
- Credit gating: fifo_free held at 100, burst_len 0x3F, size 0x1000, R stalled.
  - Exactly one AR (len 63) is issued, then `ar_valid_o` stays low.
  - After 28 R beats a second AR is allowed only once `fifo_free_i >= inflight + 64`.
- AR backpressure: `ar_ready_i` low for 10 cycles while `enable_i` drops and `fifo_free_i` changes → `ar_valid_o`, `ar_addr_o` and `ar_len_o` stay constant. After the handshake the block goes to DRAIN with no `frame_done_o`.
- Odd sizes: size 0 gives a `frame_done_o` pulse at t+1 with no AR. Size 9 (Bpb 8) gives a single AR with len 1.
- Overrun: a second `frame_start_i` during DRAIN gives an `overrun_o` pulse, the current frame completes normally, and no new fetch starts.
- Reset mid-burst: assert `rst_ni=0` for one cycle while `ar_valid_o=1` → all outputs return to reset values the next cycle. The next `frame_start_i` fetches from base with full credits.
